arcade_input_ctrl: RTL and testbench

- Parametrised per-core input conditioner between hps_io joystick words and the game core's input ports.
- Replaces ad-hoc OR-merging and control-mode muxing in each core's top level.
- Provides per-bit debounce, player merge/select, a Defender-style thrust/reverse control mode, a coin pulse stretcher, per-button autofire, and a one-shot pause pulse.
- All outputs are registered in the clk_sys domain.

---
 rtl/arcade_input_ctrl.sv | 164 ++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// Input conditioner between hps_io joystick words and a game core: debounce,
// player merge/select, thrust/reverse mode, coin stretcher, autofire, pause pulse.
module arcade_input_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BTN     = 5,
    parameter int DEB_CYCLES  = 16,
    parameter int COIN_CYCLES = 50000,
    parameter int AF_HALF     = 120000,
    localparam int AP_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [NUM_PLAYERS*32-1:0]   joy_in,
    input  logic [1:0]                  mode,
    input  logic [AP_W-1:0]             active_player,
    input  logic                        facing,
    input  logic [NUM_BTN-1:0]          autofire_en,
    output logic [3:0]                  dir_out,
    output logic                        thrust_out,
    output logic                        reverse_out,
    output logic [NUM_BTN-1:0]          fire_out,
    output logic [1:0]                  start_out,
    output logic                        coin_out,
    output logic                        pause_pulse
);
    localparam int W       = NUM_BTN + 8;
    localparam int B_S1    = 4 + NUM_BTN;
    localparam int B_S2    = 5 + NUM_BTN;
    localparam int B_COIN  = 6 + NUM_BTN;
    localparam int B_PAUSE = 7 + NUM_BTN;
    localparam int CC_W    = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
    localparam int AF_W    = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

    logic [NUM_PLAYERS-1:0][W-1:0] samp;
    logic [NUM_PLAYERS-1:0][W-1:0] db;
    logic [W-1:0]                  comb;
    logic                          samp_coin;
    logic [NUM_BTN-1:0]            btn;
    logic                          af_active;
    logic                          coin_rise;
    logic                          coin_prev;
    logic                          coin_lock;
    logic                          pause_prev;
    logic [CC_W-1:0]               coin_cnt;
    logic [AF_W-1:0]               af_cnt;
    logic                          af_phase;
    logic                          unused_joy;

    assign unused_joy = ^joy_in;

    // Sample stage is deliberately not reset so it still tracks joy_in during reset.
    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            samp[p] <= joy_in[p*32 +: W];
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) db <= '0;
                else          db <= samp;
            end
        end else begin : g_deb
            localparam int DB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            logic [DB_W-1:0] cnt [NUM_PLAYERS][W];

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    db <= '0;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        for (int b = 0; b < W; b++) cnt[p][b] <= '0;
                    end
                end else begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        for (int b = 0; b < W; b++) begin
                            if (samp[p][b] == db[p][b]) begin
                                cnt[p][b] <= '0;
                            end else if (cnt[p][b] == DB_W'(DEB_CYCLES - 1)) begin
                                db[p][b]  <= samp[p][b];
                                cnt[p][b] <= '0;
                            end else begin
                                cnt[p][b] <= cnt[p][b] + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // Out-of-range active_player matches no word, so mode 2 yields zeros.
    always_comb begin
        comb      = '0;
        samp_coin = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (mode != 2'd2) begin
                comb      = comb | db[p];
                samp_coin = samp_coin | samp[p][B_COIN];
            end else if (int'(active_player) == p) begin
                comb      = db[p];
                samp_coin = samp[p][B_COIN];
            end
        end
    end

    assign btn       = comb[4 +: NUM_BTN];
    assign af_active = |(btn & autofire_en);
    // coin_lock keeps a coin held across reset from firing; it clears once the raw coin is seen low.
    assign coin_rise = comb[B_COIN] & ~coin_prev & ~coin_lock;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_out     <= '0;
            thrust_out  <= 1'b0;
            reverse_out <= 1'b0;
            fire_out    <= '0;
            start_out   <= '0;
            coin_out    <= 1'b0;
            pause_pulse <= 1'b0;
            coin_prev   <= 1'b0;
            coin_lock   <= 1'b1;
            pause_prev  <= 1'b0;
            coin_cnt    <= '0;
            af_cnt      <= '0;
            af_phase    <= 1'b1;
        end else begin
            if (mode == 2'd1) begin
                dir_out     <= {comb[3], comb[2], 2'b00};
                thrust_out  <= facing ? comb[0] : comb[1];
                reverse_out <= facing ? comb[1] : comb[0];
            end else begin
                dir_out     <= comb[3:0];
                thrust_out  <= 1'b0;
                reverse_out <= 1'b0;
            end
            fire_out    <= btn & ~(autofire_en & {NUM_BTN{~af_phase}});
            start_out   <= {comb[B_S2], comb[B_S1]};
            pause_prev  <= comb[B_PAUSE];
            pause_pulse <= comb[B_PAUSE] & ~pause_prev;
            coin_prev   <= comb[B_COIN];
            coin_lock   <= coin_lock & samp_coin;

            // coin_cnt holds the remaining high cycles after the current one.
            if (coin_out) begin
                if (coin_cnt != '0) coin_cnt <= coin_cnt - 1'b1;
                else                coin_out <= 1'b0;
            end else if (coin_rise) begin
                coin_out <= 1'b1;
                coin_cnt <= CC_W'(COIN_CYCLES - 1);
            end

            if (!af_active) begin
                af_cnt   <= '0;
                af_phase <= 1'b1;
            end else if (af_cnt == AF_W'(AF_HALF - 1)) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: steady-state vector table plus timed sequences
// for debounce, facing, autofire, coin, pause and mid-pulse reset.
module tb_arcade_input_ctrl;
  localparam int OW = 15;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] joy_in;
  logic [1:0]  mode;
  logic        active_player;
  logic        facing;
  logic [4:0]  autofire_en;
  logic [3:0]  dir_out;
  logic        thrust_out;
  logic        reverse_out;
  logic [4:0]  fire_out;
  logic [1:0]  start_out;
  logic        coin_out;
  logic        pause_pulse;
  logic [OW-1:0] obs;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(
    .NUM_PLAYERS(2), .NUM_BTN(5), .DEB_CYCLES(4), .COIN_CYCLES(8), .AF_HALF(3)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .joy_in(joy_in), .mode(mode),
    .active_player(active_player), .facing(facing), .autofire_en(autofire_en),
    .dir_out(dir_out), .thrust_out(thrust_out), .reverse_out(reverse_out),
    .fire_out(fire_out), .start_out(start_out), .coin_out(coin_out),
    .pause_pulse(pause_pulse)
  );

  // obs: {dir[3:0], thrust, reverse, fire[4:0], start[1:0], coin, pause}
  assign obs = {dir_out, thrust_out, reverse_out, fire_out, start_out, coin_out, pause_pulse};

  localparam logic [OW-1:0] M_ALL   = '1;
  localparam logic [OW-1:0] M_FIRE0 = 15'h0010;
  localparam logic [OW-1:0] M_FIRE1 = 15'h0020;
  localparam logic [OW-1:0] M_COIN  = 15'h0002;
  localparam logic [OW-1:0] M_PAUSE = 15'h0001;

  logic [OW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] j0;
    logic [31:0] j1;
    logic [1:0]  md;
    logic        ap;
    logic        fc;
    logic [3:0]  dir;
    logic        thr;
    logic        rev;
    logic [4:0]  fire;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [OW-1:0] mk(logic [3:0] d, logic t, logic r, logic [4:0] f,
                                       logic [1:0] s, logic c, logic p);
    return {d, t, r, f, s, c, p};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(string name, logic [OW-1:0] mask);
    logic [OW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", name, obs);
      return;
    end
    e = exp_q.pop_front();
    if (((obs ^ e) & mask) != '0) begin
      bad++;
      $display("FAIL %s: got %b need %b (mask %b)", name, obs & mask, e & mask, mask);
    end
  endtask

  // Press bits on player 1 for `hold` cycles; the masked outputs must be high
  // exactly for cycles lo..hi counted from the press.
  task automatic press_seq(string name, logic [31:0] bits, int hold, int n,
                           logic [OW-1:0] mask, int lo, int hi);
    for (int k = 1; k <= n; k++) exp_q.push_back((k >= lo && k <= hi) ? mask : '0);
    joy_in[31:0] = bits;
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s_k%0d", name, k), mask);
      if (k == hold) joy_in[31:0] = '0;
    end
    repeat (10) tick();
  endtask

  initial begin
    joy_in        = '0;
    mode          = 2'd0;
    active_player = 1'b0;
    facing        = 1'b1;
    autofire_en   = '0;

    vecs[0]  = '{32'h0,    32'h0,   2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'b00000, 2'b00};
    vecs[1]  = '{32'h0,    32'h1,   2'd0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 5'b00000, 2'b00};
    vecs[2]  = '{32'h0,    32'h1,   2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'b00000, 2'b00};
    vecs[3]  = '{32'h0,    32'h1,   2'd2, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 5'b00000, 2'b00};
    vecs[4]  = '{32'h0,    32'h1,   2'd3, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 5'b00000, 2'b00};
    vecs[5]  = '{32'h18,   32'h402, 2'd0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 5'b00001, 2'b10};
    vecs[6]  = '{32'h18,   32'h402, 2'd2, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 5'b00001, 2'b00};
    vecs[7]  = '{32'h18,   32'h402, 2'd2, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 5'b00000, 2'b10};
    vecs[8]  = '{32'h2,    32'h0,   2'd1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 5'b00000, 2'b00};
    vecs[9]  = '{32'h2,    32'h0,   2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 5'b00000, 2'b00};
    vecs[10] = '{32'h7,    32'h0,   2'd1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 5'b00000, 2'b00};
    vecs[11] = '{32'h9,    32'h0,   2'd1, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 5'b00000, 2'b00};
    vecs[12] = '{32'h1F,   32'h300, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 5'b10001, 2'b01};
    vecs[13] = '{32'h0,    32'h1,   2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 5'b00000, 2'b00};

    // reset state and first cycle after release
    #3;
    exp_q.push_back('0);
    check("reset_state", M_ALL);
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    exp_q.push_back('0);
    tick();
    check("first_after_reset", M_ALL);

    // steady-state vector table
    for (int i = 0; i < 14; i++) begin
      joy_in        = {vecs[i].j1, vecs[i].j0};
      mode          = vecs[i].md;
      active_player = vecs[i].ap;
      facing        = vecs[i].fc;
      exp_q.push_back(mk(vecs[i].dir, vecs[i].thr, vecs[i].rev, vecs[i].fire, vecs[i].st,
                         1'b0, 1'b0));
      repeat (8) tick();
      check($sformatf("vec%0d", i), M_ALL);
    end
    joy_in = '0;
    mode   = 2'd0;
    facing = 1'b1;
    repeat (10) tick();

    // debounce: 3-cycle glitch rejected, 10-cycle press appears after 6 cycles
    press_seq("glitch", 32'h10, 3, 12, M_FIRE0, 1, 0);
    press_seq("deb_fire0", 32'h10, 10, 20, M_FIRE0, 6, 15);

    // facing change acts one cycle later
    mode = 2'd1;
    joy_in[31:0] = 32'h2;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 5'b0, 2'b0, 1'b0, 1'b0));
    repeat (8) tick();
    check("face_right", M_ALL);
    facing = 1'b0;
    exp_q.push_back(mk(4'b0000, 1'b1, 1'b0, 5'b0, 2'b0, 1'b0, 1'b0));
    tick();
    check("face_left_next", M_ALL);
    facing = 1'b1;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 5'b0, 2'b0, 1'b0, 1'b0));
    tick();
    check("face_right_next", M_ALL);
    joy_in = '0;
    mode   = 2'd0;
    repeat (10) tick();

    // autofire on fire1, plain fire0 alongside
    autofire_en = 5'b00010;
    for (int k = 1; k <= 22; k++) begin
      logic f0, f1;
      f0 = (k >= 6);
      f1 = (k >= 6) && ((((k - 6) / 3) % 2) == 0);
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, {3'b000, f1, f0}, 2'b0, 1'b0, 1'b0));
    end
    joy_in[31:0] = 32'h30;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check($sformatf("autofire_k%0d", k), M_FIRE0 | M_FIRE1);
      if (k == 20) joy_in[31:0] = '0;
    end
    repeat (12) tick();
    autofire_en = '0;

    // coin: held long gives one pulse; short bounce mid-pulse gives nothing more
    press_seq("coin_hold", 32'h800, 40, 50, M_COIN, 6, 13);
    for (int k = 1; k <= 38; k++) exp_q.push_back((k >= 6 && k <= 13) ? M_COIN : '0);
    joy_in[31:0] = 32'h800;
    for (int k = 1; k <= 38; k++) begin
      tick();
      check($sformatf("coin_bounce_k%0d", k), M_COIN);
      if (k == 8)  joy_in[31:0] = '0;
      if (k == 10) joy_in[31:0] = 32'h800;
      if (k == 30) joy_in[31:0] = '0;
    end
    repeat (10) tick();
    press_seq("coin_again", 32'h800, 20, 28, M_COIN, 6, 13);

    // pause: single-cycle pulse
    press_seq("pause", 32'h1000, 15, 24, M_PAUSE, 6, 6);

    // reset during an active coin pulse, coin still held afterwards
    for (int k = 1; k <= 8; k++) exp_q.push_back((k >= 6) ? M_COIN : '0);
    joy_in[31:0] = 32'h800;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("pre_reset_k%0d", k), M_COIN);
    end
    reset_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check("reset_mid_pulse", M_ALL);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) exp_q.push_back('0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("held_after_reset_k%0d", k), M_COIN);
    end
    joy_in[31:0] = '0;
    repeat (10) tick();
    press_seq("coin_repress", 32'h800, 12, 20, M_COIN, 6, 13);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: %0d entries left, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
